mips_multicycle_controller: RTL and testbench
=============================================

// Module: mips_multicycle_controller
// PURPOSE
//  Moore FSM sequencing a multi-cycle MIPS datapath: shared instruction/data memory, IR, ALUOut, PC.
//  Each instruction walks FETCH -> DECODE -> execute states.
//  Drives every datapath enable and select from the state, the IR opcode and the IR func.
//  Sits next to the datapath in the multi-cycle top. Replaces the combinational controller of the single-cycle core.
// PARAMETERS
//  ILLEGAL_HALT  1  1: unknown opcode/func -> HALT until reset; 0: pulse illegal_op, return to FETCH
//  WAIT_LIMIT    0  memory wait cycles before timeout (MIPS_MC_MEMWAIT_EN only); 0 = wait forever
// PORTS
//  clk           in   1  clock, rising edge
//  PCinit        in   1  synchronous active-high reset
//  opcode        in   6  IR[31:26]; stable from DECODE until the next FETCH
//  func          in   6  IR[5:0]
//  zero          in   1  ALU zero flag
//  mem_ready     in   1  memory access complete (present only with MIPS_MC_MEMWAIT_EN)
//  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite  out 1  PC, memory and IR controls
//  RegDst, MemtoReg, RegWrite, WrSel, WdSel  out 1  regfile controls; WrSel -> r31, WdSel -> write PC
//  ALUSrcA       out  1  0: PC, 1: rs
//  ALUSrcB       out  2  00: rt, 01: +4, 10: sext imm, 11: sext imm<<2
//  PCSource      out  2  00: ALU, 01: ALUOut, 10: jump target, 11: rs
//  ALUoperation  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
//  state_o       out  4  current state encoding
//  instr_done    out  1  1-cycle pulse in the final state of each instruction
//  illegal_op    out  1  1-cycle pulse in DECODE on an unknown opcode/func
//  halted        out  1  high while in HALT
// BEHAVIOUR
//  States (encoding):
//   FETCH 0 | DECODE 1 | MEMADR 2 | MEMRD 3 | MEMWB 4 | MEMWR 5 | RTEX 6 | RTWB 7
//   BEQ 8 | IMMEX 9 | IMMWB 10 | JUMP 11 | JAL 12 | JR 13 | HALT 14 | 15 unused -> FETCH
//  Outputs are decoded from state only. Any output not listed for a state is 0.
//  PCinit high at a clock edge: state <= FETCH. While PCinit is high, all outputs are forced to 0.
//  FETCH: MemRead, IRWrite, PCWrite, ALUSrcB=01, add, PCSource=00 -> DECODE
//  DECODE: ALUSrcB=11, add (branch target into ALUOut). Next state by opcode:
//   100011 lw / 101011 sw -> MEMADR
//   000000 with func add 100000 / sub 100010 / and 100100 / or 100101 / slt 101010 -> RTEX
//   000000 with func 001000 jr -> JR
//   000100 beq -> BEQ;  001000 addi / 001010 slti -> IMMEX;  000010 j -> JUMP;  000011 jal -> JAL
//   anything else: illegal_op=1, then HALT if ILLEGAL_HALT else FETCH
//  MEMADR: ALUSrcA=1, ALUSrcB=10, add -> MEMRD (lw) or MEMWR (sw)
//  MEMRD: IorD, MemRead -> MEMWB.   MEMWB: MemtoReg, RegWrite, done -> FETCH
//  MEMWR: IorD, MemWrite, done -> FETCH
//  RTEX: ALUSrcA=1, ALUSrcB=00, ALUoperation from func -> RTWB.   RTWB: RegDst, RegWrite, done -> FETCH
//  BEQ: ALUSrcA=1, sub, PCWriteCond, PCSource=01, done -> FETCH. The datapath gates PCWriteCond with zero.
//  IMMEX: ALUSrcA=1, ALUSrcB=10, add (addi) or slt (slti) -> IMMWB.   IMMWB: RegWrite, done -> FETCH
//  JUMP: PCWrite, PCSource=10, done.   JAL: adds WrSel, WdSel, RegWrite.   JR: PCWrite, PCSource=11, done. All -> FETCH
//  HALT: all controls 0, halted=1. Leaves only on PCinit.
//  Latency in cycles: lw 5; sw 4; R-type 4; addi/slti 4; beq 3; j/jal/jr 3.
//  instr_done is high in exactly one cycle per legal instruction.
// CONFIGURATION
//  MIPS_MC_MEMWAIT_EN defined:
//   - FETCH, MEMRD and MEMWR hold their state, MemRead/MemWrite and IorD until mem_ready=1.
//   - IRWrite, PCWrite and instr_done (MEMWR) assert only in the cycle with mem_ready=1.
//   - With WAIT_LIMIT>0: WAIT_LIMIT consecutive wait cycles without mem_ready -> HALT.
//   - The wait counter clears on each state change and on reset.
//  MIPS_MC_MEMWAIT_EN undefined: mem_ready port absent; every memory state lasts exactly 1 cycle.
// TESTING
//  PCinit high 2 cycles, then low -> cycle 0: state_o=0, MemRead=IRWrite=PCWrite=1; cycle 1: state_o=1.
//  opcode 100011 -> state_o sequence 0,1,2,3,4; cycle 4: MemtoReg=RegWrite=instr_done=1; cycle 5: 0.
//  opcode 000000, func 101010 -> RTEX with ALUoperation=111; RTWB with RegDst=RegWrite=1.
//  opcode 000100 -> BEQ: PCWriteCond=1, PCSource=01, ALUoperation=110, 3 cycles total.
//  opcode 000011 -> JAL: WrSel=WdSel=RegWrite=PCWrite=1, PCSource=10.
//  opcode 111111, ILLEGAL_HALT=1 -> illegal_op pulse; halted=1 and all controls 0 until PCinit.
//  MIPS_MC_MEMWAIT_EN, mem_ready low 3 cycles in MEMRD -> state_o=3 held 4 cycles, then MEMWB.
//  PCinit asserted in MEMWB -> RegWrite 0 that cycle, FETCH next cycle.

Source files
------------

// File: rtl/mips_multicycle_controller.sv
// mips_multicycle_controller: Moore FSM driving the multi-cycle MIPS datapath controls from state, opcode and func.
// Define MIPS_MC_MEMWAIT_EN to stall FETCH/MEMRD/MEMWR on mem_ready, with an optional WAIT_LIMIT timeout to HALT.
module mips_multicycle_controller #(
    parameter bit ILLEGAL_HALT = 1'b1,
    parameter int WAIT_LIMIT   = 0
) (
    input  logic       clk,
    input  logic       PCinit,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       zero,
`ifdef MIPS_MC_MEMWAIT_EN
    input  logic       mem_ready,
`endif
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       WrSel,
    output logic       WdSel,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [2:0] ALUoperation,
    output logic [3:0] state_o,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       halted
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEX, RTWB,
        BEQ, IMMEX, IMMWB, JUMP, JAL, JR, HALT, UNUSED
    } state_t;

    typedef struct packed {
        logic [3:0] st;
        logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
        logic       regdst, memtoreg, regwrite, wrsel, wdsel, alusrca;
        logic [1:0] alusrcb, pcsource;
        logic [2:0] aluop;
        logic       done, ill, halted;
    } ctl_t;

    state_t state, state_next, target;
    ctl_t   c;
    logic   mem_ok, timeout, illegal;
    logic   unused_zero;

    // zero is consumed by the datapath's PCWriteCond gate, not here
    assign unused_zero = zero;

`ifdef MIPS_MC_MEMWAIT_EN
    logic [15:0] wait_cnt;
    logic        waiting;
    assign mem_ok  = mem_ready;
    assign waiting = (state == FETCH || state == MEMRD || state == MEMWR) && !mem_ready;
    assign timeout = (WAIT_LIMIT > 0) && waiting && wait_cnt == 16'(WAIT_LIMIT - 1);
    always_ff @(posedge clk)
        wait_cnt <= (PCinit || !waiting || state_next != state) ? '0 : wait_cnt + 16'd1;
`else
    localparam int unused_wait_limit = WAIT_LIMIT;
    assign mem_ok  = 1'b1;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk)
        state <= PCinit ? FETCH : state_next;

    always_comb begin
        illegal = 1'b0;
        target  = FETCH;
        case (opcode)
            6'b100011, 6'b101011: target = MEMADR;
            6'b000000:
                case (func)
                    6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: target = RTEX;
                    6'b001000: target = JR;
                    default:   illegal = 1'b1;
                endcase
            6'b000100:            target = BEQ;
            6'b001000, 6'b001010: target = IMMEX;
            6'b000010:            target = JUMP;
            6'b000011:            target = JAL;
            default:              illegal = 1'b1;
        endcase
        if (illegal) target = ILLEGAL_HALT ? HALT : FETCH;
        state_next = FETCH;
        case (state)
            FETCH:  state_next = timeout ? HALT : mem_ok ? DECODE : FETCH;
            DECODE: state_next = target;
            MEMADR: state_next = (opcode == 6'b100011) ? MEMRD : MEMWR;
            MEMRD:  state_next = timeout ? HALT : mem_ok ? MEMWB : MEMRD;
            MEMWR:  state_next = timeout ? HALT : mem_ok ? FETCH : MEMWR;
            RTEX:   state_next = RTWB;
            IMMEX:  state_next = IMMWB;
            HALT:   state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        c    = '0;
        c.st = state;
        case (state)
            FETCH: begin
                c.memread = 1'b1;
                c.irwrite = mem_ok;
                c.pcwrite = mem_ok;
                c.alusrcb = 2'b01;
                c.aluop   = 3'b010;
            end
            DECODE: begin
                c.alusrcb = 2'b11;
                c.aluop   = 3'b010;
                c.ill     = illegal;
            end
            MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                c.aluop   = 3'b010;
            end
            MEMRD: begin
                c.iord    = 1'b1;
                c.memread = 1'b1;
            end
            MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
                c.done     = 1'b1;
            end
            MEMWR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
                c.done     = mem_ok;
            end
            RTEX: begin
                c.alusrca = 1'b1;
                c.aluop   = (func == 6'b100010) ? 3'b110 : (func == 6'b100100) ? 3'b000 :
                            (func == 6'b100101) ? 3'b001 : (func == 6'b101010) ? 3'b111 : 3'b010;
            end
            RTWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
                c.done     = 1'b1;
            end
            BEQ: begin
                c.alusrca     = 1'b1;
                c.aluop       = 3'b110;
                c.pcwritecond = 1'b1;
                c.pcsource    = 2'b01;
                c.done        = 1'b1;
            end
            IMMEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                c.aluop   = (opcode == 6'b001010) ? 3'b111 : 3'b010;
            end
            IMMWB: begin
                c.regwrite = 1'b1;
                c.done     = 1'b1;
            end
            JUMP, JAL: begin
                c.pcwrite  = 1'b1;
                c.pcsource = 2'b10;
                c.done     = 1'b1;
                c.wrsel    = state == JAL;
                c.wdsel    = state == JAL;
                c.regwrite = state == JAL;
            end
            JR: begin
                c.pcwrite  = 1'b1;
                c.pcsource = 2'b11;
                c.done     = 1'b1;
            end
            HALT: c.halted = 1'b1;
            default: c.st = state;
        endcase
    end

    assign {state_o, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
            RegWrite, WrSel, WdSel, ALUSrcA, ALUSrcB, PCSource, ALUoperation, instr_done,
            illegal_op, halted} = PCinit ? '0 : c;
endmodule

// File: tb/tb_mips_multicycle_controller.sv
// tb_mips_multicycle_controller: scoreboard bench; per-instruction output sequences come from an instruction-level model.
module tb_mips_multicycle_controller;
    localparam bit ILH = 1'b1;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, pcwc, iord, mr, mw, irw, rd, m2r, rw, wrs, wds, srca;
        logic [1:0] srcb, pcs;
        logic [2:0] op;
        logic       done, ill, halt;
    } exp_t;

    typedef struct {
        exp_t  v;
        string nm;
    } item_t;

    logic       clk = 1'b0;
    logic       PCinit = 1'b1;
    logic [5:0] opcode = '0, func = '0;
    logic       zero = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg;
    logic       RegWrite, WrSel, WdSel, ALUSrcA, instr_done, illegal_op, halted;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUoperation;
    logic [3:0] state_o;
    exp_t       act;
    item_t      q[$];
    int         vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    mips_multicycle_controller #(.ILLEGAL_HALT(ILH), .WAIT_LIMIT(0)) dut (
        .clk(clk), .PCinit(PCinit), .opcode(opcode), .func(func), .zero(zero),
`ifdef MIPS_MC_MEMWAIT_EN
        .mem_ready(1'b1),
`endif
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .WrSel(WrSel), .WdSel(WdSel), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUoperation(ALUoperation),
        .state_o(state_o), .instr_done(instr_done), .illegal_op(illegal_op), .halted(halted)
    );

    assign act = {state_o, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
                  RegWrite, WrSel, WdSel, ALUSrcA, ALUSrcB, PCSource, ALUoperation, instr_done,
                  illegal_op, halted};

    function automatic string kind(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'b100011) return "lw";
        if (op == 6'b101011) return "sw";
        if (op == 6'b000100) return "beq";
        if (op == 6'b001000) return "addi";
        if (op == 6'b001010) return "slti";
        if (op == 6'b000010) return "j";
        if (op == 6'b000011) return "jal";
        if (op == 6'b000000 && fn == 6'b001000) return "jr";
        if (op == 6'b000000 && fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010}) return "r";
        return "ill";
    endfunction

    function automatic logic [2:0] rop(input logic [5:0] fn);
        case (fn)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // rst_at >= 0: PCinit is held for one cycle in place of that cycle of the instruction
    task automatic run(input logic [5:0] op, input logic [5:0] fn, input int rst_at, input string nm);
        exp_t  s[$];
        string k;
        int    ra;
        bit    il;
        k  = kind(op, fn);
        ra = rst_at;
        il = (k == "ill");
        s.push_back('{st:4'd0, pcw:1'b1, mr:1'b1, irw:1'b1, srcb:2'b01, op:3'b010, default:'0});
        s.push_back('{st:4'd1, srcb:2'b11, op:3'b010, ill:il, default:'0});
        if (k == "lw" || k == "sw")
            s.push_back('{st:4'd2, srca:1'b1, srcb:2'b10, op:3'b010, default:'0});
        if (k == "lw") begin
            s.push_back('{st:4'd3, iord:1'b1, mr:1'b1, default:'0});
            s.push_back('{st:4'd4, m2r:1'b1, rw:1'b1, done:1'b1, default:'0});
        end else if (k == "sw") begin
            s.push_back('{st:4'd5, iord:1'b1, mw:1'b1, done:1'b1, default:'0});
        end else if (k == "r") begin
            s.push_back('{st:4'd6, srca:1'b1, srcb:2'b00, op:rop(fn), default:'0});
            s.push_back('{st:4'd7, rd:1'b1, rw:1'b1, done:1'b1, default:'0});
        end else if (k == "beq") begin
            s.push_back('{st:4'd8, srca:1'b1, op:3'b110, pcwc:1'b1, pcs:2'b01, done:1'b1, default:'0});
        end else if (k == "addi" || k == "slti") begin
            s.push_back('{st:4'd9, srca:1'b1, srcb:2'b10, op:(k == "slti") ? 3'b111 : 3'b010, default:'0});
            s.push_back('{st:4'd10, rw:1'b1, done:1'b1, default:'0});
        end else if (k == "j") begin
            s.push_back('{st:4'd11, pcw:1'b1, pcs:2'b10, done:1'b1, default:'0});
        end else if (k == "jal") begin
            s.push_back('{st:4'd12, pcw:1'b1, pcs:2'b10, wrs:1'b1, wds:1'b1, rw:1'b1, done:1'b1, default:'0});
        end else if (k == "jr") begin
            s.push_back('{st:4'd13, pcw:1'b1, pcs:2'b11, done:1'b1, default:'0});
        end else if (ILH) begin
            repeat (3) s.push_back('{st:4'd14, halt:1'b1, default:'0});
            if (ra < 0) ra = s.size();
        end
        while (ra >= 0 && s.size() > ra) void'(s.pop_back());
        opcode = op;
        func   = fn;
        zero   = 1'($urandom);
        foreach (s[i]) q.push_back('{s[i], nm});
        repeat (s.size()) @(posedge clk);
        #1;
        if (ra >= 0) begin
            PCinit = 1'b1;
            q.push_back('{exp_t'('0), {nm, "_rst"}});
            @(posedge clk);
            #1;
            PCinit = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                item_t it;
                it = q.pop_front();
                vectors++;
                if (act !== it.v) begin
                    miscompares++;
                    $display("FAIL %s: got %h expected %h (t=%0t)", it.nm, act, it.v, $time);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish, %0d vectors so far", vectors);
        $fatal(1);
    end

    initial begin
        logic [11:0] legal [12];
        logic [11:0] pick;
        legal = '{{6'b100011, 6'd0}, {6'b101011, 6'd0}, {6'd0, 6'b100000}, {6'd0, 6'b100010},
                  {6'd0, 6'b100100}, {6'd0, 6'b100101}, {6'd0, 6'b101010}, {6'd0, 6'b001000},
                  {6'b000100, 6'd0}, {6'b001000, 6'd0}, {6'b001010, 6'd0}, {6'b000011, 6'd0}};
        @(posedge clk);
        #1;
        PCinit = 1'b1;
        repeat (2) q.push_back('{exp_t'('0), "reset"});
        repeat (2) @(posedge clk);
        #1;
        PCinit = 1'b0;
        run(6'b100011, 6'd0, -1, "lw");
        run(6'b101011, 6'd5, -1, "sw");
        run(6'b000000, 6'b101010, -1, "slt");
        run(6'b000100, 6'd0, -1, "beq");
        run(6'b000011, 6'd0, -1, "jal");
        run(6'b000010, 6'd0, -1, "j");
        run(6'b000000, 6'b001000, -1, "jr");
        run(6'b001010, 6'd0, -1, "slti");
        run(6'b100011, 6'd0, 4, "lw_rst_memwb");
        run(6'b111111, 6'b111111, -1, "illegal");
        run(6'b000000, 6'b111111, -1, "illegal_func");
        for (int n = 0; n < 300; n++) begin
            pick = ($urandom_range(0, 4) != 0) ? legal[$urandom_range(0, 11)] : 12'($urandom);
            run(pick[11:6], pick[5:0], ($urandom_range(0, 9) == 0) ? $urandom_range(0, 5) : -1, "rnd");
        end
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
